biquad_coeff_bank: RTL and testbench
====================================

BIQUAD_COEFF_BANK -- requirements
Module: biquad_coeff_bank

Interface
REQ-001 SHALL have parameter NCHAN, default 2: number of independent biquad8 channels served (1..8).
REQ-002 SHALL have parameter CBITS, default 18: coefficient width, two's complement.
REQ-003 SHALL have port clk_i  input  1  single clock; the WISHBONE interface and the coefficient outputs run on it.
REQ-004 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports wb_cyc_i, wb_stb_i, wb_we_i  input  1 each  WISHBONE strobes.
REQ-006 SHALL have ports wb_adr_i (input, 7), wb_dat_i (input, 32), wb_sel_i (input, 4): address, write data and byte select; wb_sel_i is ignored.
REQ-007 SHALL have ports wb_dat_o (output, 32) and wb_ack_o (output, 1): read data and acknowledge.
REQ-008 SHALL have port global_update_i  input  1  commits every channel.
REQ-009 SHALL have port coeff_o  output  NCHAN*25*CBITS  active coefficients, channel-major, slot order per package map.
REQ-010 SHALL have port update_o  output  NCHAN  per-channel one-cycle pulse signalling that the active set changed.

Function
REQ-011 SHALL use a fixed group map with base addresses 0x04/0x08/0x0C/0x10/0x14/0x18/0x1C and depths 8/4/4/3/4/1/1 (zero FIR, C, incremental, F chain, G chain, F cross, G cross); 25 slots.
REQ-012 SHALL hold a shadow bank and an active bank per channel; only the active bank drives coeff_o.
REQ-013 SHALL decode 0x00 as control and 0x20 as channel select (bits[2:0]); select values >= NCHAN SHALL be ignored on write.
REQ-014 SHALL assert wb_ack_o for exactly one cycle, in the cycle after wb_cyc_i&wb_stb_i is first seen high with wb_ack_o low; there are no wait states and no back-to-back acks.
REQ-015 SHALL, on a group write, store wb_dat_i[CBITS-1:0] into shadow slot ptr of that group in the selected channel on the acking edge, then advance ptr modulo depth.
REQ-016 SHALL, on a control write with bit0=1, copy shadow to active for the selected channel; if bit16=1 as well, it copies all channels.
REQ-017 SHALL treat global_update_i high as a commit of all channels.
REQ-018 SHALL, when global_update_i and a control commit coincide, perform exactly one all-channel copy and emit one update_o pulse per channel.
REQ-019 SHALL load the active bank on the commit edge and assert update_o for the committed channels on the following cycle only.
REQ-020 SHALL clear every group pointer of a committed channel to 0 on commit.
REQ-021 SHALL latch the channel's sticky err[group] bit if any group pointer is nonzero at commit (partial load); the commit still proceeds.
REQ-022 SHALL clear the err bits of the selected channel on a control write with bit31=1.
REQ-023 SHALL return the following on reads: control = {err[6:0] at [14:8], selected channel at [2:0]}; group address = {ptr in [3:0]}; channel select = select value; unmapped = 0.
REQ-024 SHALL make unmapped writes no-ops that are still acked.
REQ-025 SHALL make slot pointers wrap: the ninth write to a depth-8 group overwrites slot 0.

Reset
REQ-026 SHALL, while rst_ni is low at a clock edge, clear shadow, active, pointers, err, channel select, wb_ack_o, wb_dat_o and update_o to 0.
REQ-027 SHALL make a reset that arrives mid-cycle abort the transaction without ack; the master must retry.

Structure
REQ-028 SHALL place group base addresses, depths, slot offsets and the total (25) as localparams in package biquad_coeff_pkg.
REQ-029 SHALL implement one sub-module, biquad_coeff_chan (shadow, active, pointers and err for one channel), instantiated NCHAN times.

Verification
REQ-030 SHALL verify this: write 18'h3FDAF/18'h0375A alternately 8x to 0x04, then 0x00=0x1 -> channel 0 zero-FIR slots match, update_o[0] pulses once, err=0.
REQ-031 SHALL verify this: write 0x10 with 18'h2205 and 18'h251 only, then commit -> err bit for group F chain set, readback 0x00 bit[11]=1, active slots 0..1 updated.
REQ-032 SHALL verify this: select channel 1, write 18'h277 to 0x1C, assert global_update_i the same cycle as a 0x00=0x10001 commit -> both channels copy once, update_o=2'b11 for one cycle.
REQ-033 SHALL verify this: write 9 values to 0x04 -> slot 0 holds the ninth value, ptr readback=1.
REQ-034 SHALL verify this: drop rst_ni during an active cyc -> no ack, all outputs 0 next cycle, retried write succeeds.
REQ-035 SHALL verify this: write 0x20=7 with NCHAN=2 -> select stays at its prior value and the readback confirms it.

Source files
------------

// File: rtl/biquad_coeff_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : biquad_coeff_pkg                                                 |
// | Purpose : Register/group map shared by the biquad coefficient bank.        |
// |           Seven coefficient groups are packed into 25 slots per channel.   |
// |           Each group is written through one address that auto-increments.  |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package biquad_coeff_pkg;

  localparam int NGROUPS = 7;
  localparam int NSLOTS  = 25;
  localparam int PTR_W   = 4;

  localparam logic [6:0] ADDR_CTRL = 7'h00;
  localparam logic [6:0] ADDR_SEL  = 7'h20;

  typedef enum logic [2:0] {
    GRP_ZFIR  = 3'd0,  // zero FIR
    GRP_C     = 3'd1,  // C
    GRP_INC   = 3'd2,  // incremental
    GRP_FCH   = 3'd3,  // F chain
    GRP_GCH   = 3'd4,  // G chain
    GRP_FX    = 3'd5,  // F cross
    GRP_GX    = 3'd6   // G cross
  } grp_e;

  localparam logic [6:0] BASE_ZFIR = 7'h04;
  localparam logic [6:0] BASE_C    = 7'h08;
  localparam logic [6:0] BASE_INC  = 7'h0C;
  localparam logic [6:0] BASE_FCH  = 7'h10;
  localparam logic [6:0] BASE_GCH  = 7'h14;
  localparam logic [6:0] BASE_FX   = 7'h18;
  localparam logic [6:0] BASE_GX   = 7'h1C;

  localparam logic [3:0] DEPTH_ZFIR = 4'd8;
  localparam logic [3:0] DEPTH_C    = 4'd4;
  localparam logic [3:0] DEPTH_INC  = 4'd4;
  localparam logic [3:0] DEPTH_FCH  = 4'd3;
  localparam logic [3:0] DEPTH_GCH  = 4'd4;
  localparam logic [3:0] DEPTH_FX   = 4'd1;
  localparam logic [3:0] DEPTH_GX   = 4'd1;

  localparam logic [4:0] OFS_ZFIR = 5'd0;
  localparam logic [4:0] OFS_C    = 5'd8;
  localparam logic [4:0] OFS_INC  = 5'd12;
  localparam logic [4:0] OFS_FCH  = 5'd16;
  localparam logic [4:0] OFS_GCH  = 5'd19;
  localparam logic [4:0] OFS_FX   = 5'd23;
  localparam logic [4:0] OFS_GX   = 5'd24;

  function automatic logic [6:0] grp_base(input logic [2:0] g);
    case (g)
      GRP_ZFIR: grp_base = BASE_ZFIR;
      GRP_C:    grp_base = BASE_C;
      GRP_INC:  grp_base = BASE_INC;
      GRP_FCH:  grp_base = BASE_FCH;
      GRP_GCH:  grp_base = BASE_GCH;
      GRP_FX:   grp_base = BASE_FX;
      GRP_GX:   grp_base = BASE_GX;
      default:  grp_base = ADDR_CTRL;
    endcase
  endfunction

  function automatic logic [3:0] grp_depth(input logic [2:0] g);
    case (g)
      GRP_ZFIR: grp_depth = DEPTH_ZFIR;
      GRP_C:    grp_depth = DEPTH_C;
      GRP_INC:  grp_depth = DEPTH_INC;
      GRP_FCH:  grp_depth = DEPTH_FCH;
      GRP_GCH:  grp_depth = DEPTH_GCH;
      GRP_FX:   grp_depth = DEPTH_FX;
      GRP_GX:   grp_depth = DEPTH_GX;
      default:  grp_depth = 4'd1;
    endcase
  endfunction

  function automatic logic [4:0] grp_offset(input logic [2:0] g);
    case (g)
      GRP_ZFIR: grp_offset = OFS_ZFIR;
      GRP_C:    grp_offset = OFS_C;
      GRP_INC:  grp_offset = OFS_INC;
      GRP_FCH:  grp_offset = OFS_FCH;
      GRP_GCH:  grp_offset = OFS_GCH;
      GRP_FX:   grp_offset = OFS_FX;
      GRP_GX:   grp_offset = OFS_GX;
      default:  grp_offset = 5'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/biquad_coeff_chan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : biquad_coeff_chan                                                |
// | Purpose : One channel of the coefficient bank: shadow slots written via    |
// |           per-group auto-increment pointers, an active copy loaded on      |
// |           commit, and sticky per-group partial-load error flags.           |
// | Ports   : clk_i, rst_ni     clock, synchronous active-low reset            |
// |           wr_en_i/grp/data  shadow write into group wr_grp_i               |
// |           commit_i          copy shadow -> active, clear pointers          |
// |           err_clr_i         clear sticky error flags                       |
// |           coeff_o           active slots, slot 0 in the LSBs               |
// |           ptr_o, err_o      group pointers and error flags for readback    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module biquad_coeff_chan
  import biquad_coeff_pkg::*;
#(
  parameter int CBITS = 18
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [2:0]               wr_grp_i,
  input  logic [CBITS-1:0]         wr_data_i,
  input  logic                     commit_i,
  input  logic                     err_clr_i,
  output logic [NSLOTS*CBITS-1:0]  coeff_o,
  output logic [NGROUPS*PTR_W-1:0] ptr_o,
  output logic [NGROUPS-1:0]       err_o
);

  logic [CBITS-1:0] shadow_q [NSLOTS];
  logic [CBITS-1:0] shadow_d [NSLOTS];
  logic [CBITS-1:0] active_q [NSLOTS];
  logic [CBITS-1:0] active_d [NSLOTS];
  logic [PTR_W-1:0] ptr_q    [NGROUPS];
  logic [PTR_W-1:0] ptr_d    [NGROUPS];
  logic [NGROUPS-1:0] err_q;
  logic [NGROUPS-1:0] err_d;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    ptr_d    = ptr_q;
    err_d    = err_q;

    if (wr_en_i) begin
      for (int g = 0; g < NGROUPS; g++) begin
        if (wr_grp_i == 3'(g)) begin
          shadow_d[grp_offset(3'(g)) + 5'(ptr_q[g])] = wr_data_i;
          ptr_d[g] = (ptr_q[g] == grp_depth(3'(g)) - 4'd1) ? '0 : ptr_q[g] + 4'd1;
        end
      end
    end

    // Clear first so a commit in the same cycle still records a partial load.
    if (err_clr_i) begin
      err_d = '0;
    end

    // Commit copies the pre-edge shadow; a nonzero pointer means a group was
    // only partially reloaded, which is flagged but does not block the copy.
    if (commit_i) begin
      active_d = shadow_q;
      for (int g = 0; g < NGROUPS; g++) begin
        if (ptr_q[g] != '0) begin
          err_d[g] = 1'b1;
        end
        ptr_d[g] = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
      ptr_q    <= '{default: '0};
      err_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      ptr_q    <= ptr_d;
      err_q    <= err_d;
    end
  end

  generate
    for (genvar s = 0; s < NSLOTS; s++) begin : g_slot
      assign coeff_o[s*CBITS +: CBITS] = active_q[s];
    end
    for (genvar g = 0; g < NGROUPS; g++) begin : g_grp
      assign ptr_o[g*PTR_W +: PTR_W] = ptr_q[g];
    end
  endgenerate

  assign err_o = err_q;

endmodule
`default_nettype wire

// File: rtl/biquad_coeff_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : biquad_coeff_bank                                                |
// | Purpose : WISHBONE-programmable double-buffered coefficient bank feeding   |
// |           NCHAN biquad8 channels.                                          |
// | Ports   : clk_i, rst_ni           clock, synchronous active-low reset      |
// |           wb_*                    WISHBONE slave (sel ignored, 1-cycle ack)|
// |           global_update_i         commit all channels                      |
// |           coeff_o                 active coefficients, channel-major       |
// |           update_o                per-channel one-cycle commit pulse       |
// | Map     : 0x00 control, 0x04..0x1C groups, 0x20 channel select             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module biquad_coeff_bank
  import biquad_coeff_pkg::*;
#(
  parameter int NCHAN = 2,
  parameter int CBITS = 18
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          wb_cyc_i,
  input  logic                          wb_stb_i,
  input  logic                          wb_we_i,
  input  logic [6:0]                    wb_adr_i,
  input  logic [31:0]                   wb_dat_i,
  input  logic [3:0]                    wb_sel_i,
  output logic [31:0]                   wb_dat_o,
  output logic                          wb_ack_o,
  input  logic                          global_update_i,
  output logic [NCHAN*NSLOTS*CBITS-1:0] coeff_o,
  output logic [NCHAN-1:0]              update_o
);

  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic [2:0]        sel_q, sel_d;
  logic [NCHAN-1:0]  update_q, update_d;

  logic              w_req, w_wr, w_is_ctrl, w_is_sel, w_ctrl_wr, w_commit_all;
  logic              w_grp_hit;
  logic [2:0]        w_grp_idx;
  logic [NGROUPS*PTR_W-1:0] w_sel_ptrs;
  logic [PTR_W-1:0]  w_grp_ptr;
  logic [NGROUPS-1:0] w_sel_err;
  logic [NCHAN-1:0]  w_commit, w_wr_en, w_err_clr;
  logic [NGROUPS*PTR_W-1:0] w_chan_ptr [NCHAN];
  logic [NGROUPS-1:0]       w_chan_err [NCHAN];
  logic              w_unused;

  // Byte selects and the spare data bits carry no meaning here.
  assign w_unused = ^{wb_sel_i, wb_dat_i};

  // A request is accepted only when no ack is outstanding, which yields a
  // single-cycle ack and forbids back-to-back acks.
  assign w_req     = wb_cyc_i & wb_stb_i & ~ack_q;
  assign w_wr      = w_req & wb_we_i;
  assign w_is_ctrl = (wb_adr_i == ADDR_CTRL);
  assign w_is_sel  = (wb_adr_i == ADDR_SEL);
  assign w_ctrl_wr = w_wr & w_is_ctrl;

  // Global update and an all-channel control commit merge into one copy.
  assign w_commit_all = global_update_i | (w_ctrl_wr & wb_dat_i[0] & wb_dat_i[16]);

  always_comb begin
    w_grp_hit = 1'b0;
    w_grp_idx = '0;
    for (int g = 0; g < NGROUPS; g++) begin
      if (wb_adr_i == grp_base(3'(g))) begin
        w_grp_hit = 1'b1;
        w_grp_idx = 3'(g);
      end
    end
  end

  always_comb begin
    w_sel_ptrs = '0;
    w_sel_err  = '0;
    for (int c = 0; c < NCHAN; c++) begin
      if (sel_q == 3'(c)) begin
        w_sel_ptrs = w_chan_ptr[c];
        w_sel_err  = w_chan_err[c];
      end
    end
    w_grp_ptr = '0;
    for (int g = 0; g < NGROUPS; g++) begin
      if (w_grp_idx == 3'(g)) begin
        w_grp_ptr = w_sel_ptrs[g*PTR_W +: PTR_W];
      end
    end
  end

  always_comb begin
    ack_d    = w_req;
    sel_d    = sel_q;
    dat_d    = '0;
    update_d = w_commit;

    if (w_wr && w_is_sel && ({29'd0, wb_dat_i[2:0]} < 32'(NCHAN))) begin
      sel_d = wb_dat_i[2:0];
    end

    if (w_req && !wb_we_i) begin
      if (w_is_ctrl) begin
        dat_d = {17'd0, w_sel_err, 5'd0, sel_q};
      end else if (w_is_sel) begin
        dat_d = {29'd0, sel_q};
      end else if (w_grp_hit) begin
        dat_d = {28'd0, w_grp_ptr};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      sel_q    <= '0;
      update_q <= '0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      update_q <= update_d;
    end
  end

  generate
    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
      assign w_commit[c]  = w_commit_all | (w_ctrl_wr & wb_dat_i[0] & (sel_q == 3'(c)));
      assign w_err_clr[c] = w_ctrl_wr & wb_dat_i[31] & (sel_q == 3'(c));
      assign w_wr_en[c]   = w_wr & w_grp_hit & (sel_q == 3'(c));

      biquad_coeff_chan #(
        .CBITS (CBITS)
      ) u_chan (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_en_i   (w_wr_en[c]),
        .wr_grp_i  (w_grp_idx),
        .wr_data_i (wb_dat_i[CBITS-1:0]),
        .commit_i  (w_commit[c]),
        .err_clr_i (w_err_clr[c]),
        .coeff_o   (coeff_o[c*NSLOTS*CBITS +: NSLOTS*CBITS]),
        .ptr_o     (w_chan_ptr[c]),
        .err_o     (w_chan_err[c])
      );
    end
  endgenerate

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign update_o = update_q;

endmodule
`default_nettype wire

// File: tb/tb_biquad_coeff_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_biquad_coeff_bank                                             |
// | Purpose : Self-checking bench for biquad_coeff_bank (NCHAN=2, CBITS=18).   |
// |           A behavioural model of the register map predicts read data,      |
// |           update pulses and the active coefficient image.                  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_biquad_coeff_bank;

  localparam int NCHAN = 2;
  localparam int CBITS = 18;
  localparam int NS    = 25;
  localparam int NG    = 7;
  localparam int CW    = NCHAN*NS*CBITS;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic              wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [6:0]        wb_adr = '0;
  logic [31:0]       wb_dat = '0;
  logic              gupd = 1'b0;
  logic [31:0]       wb_dat_o;
  logic              wb_ack_o;
  logic [CW-1:0]     coeff_o;
  logic [NCHAN-1:0]  update_o;

  always #5 clk = ~clk;

  biquad_coeff_bank #(.NCHAN(NCHAN), .CBITS(CBITS)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .wb_cyc_i        (wb_cyc),
    .wb_stb_i        (wb_stb),
    .wb_we_i         (wb_we),
    .wb_adr_i        (wb_adr),
    .wb_dat_i        (wb_dat),
    .wb_sel_i        (4'hF),
    .wb_dat_o        (wb_dat_o),
    .wb_ack_o        (wb_ack_o),
    .global_update_i (gupd),
    .coeff_o         (coeff_o),
    .update_o        (update_o)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  int          depth [NG] = '{8, 4, 4, 3, 4, 1, 1};
  logic [17:0] m_shadow [NCHAN][NS];
  logic [17:0] m_active [NCHAN][NS];
  int          m_ptr    [NCHAN][NG];
  logic [6:0]  m_err    [NCHAN];
  int          m_sel;

  function automatic int first_slot(input int g);
    int s = 0;
    for (int i = 0; i < g; i++) s += depth[i];
    return s;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCHAN; c++) begin
      for (int s = 0; s < NS; s++) begin
        m_shadow[c][s] = '0;
        m_active[c][s] = '0;
      end
      for (int g = 0; g < NG; g++) m_ptr[c][g] = 0;
      m_err[c] = '0;
    end
    m_sel = 0;
  endtask

  task automatic model_step(input bit we, input logic [6:0] adr, input logic [31:0] dat,
                            input bit gu, output logic [31:0] rd, output logic [NCHAN-1:0] upd);
    int grp = -1;
    for (int g = 0; g < NG; g++) if (adr == 7'(4 + 4*g)) grp = g;
    rd  = '0;
    upd = '0;
    if (!we) begin
      if (adr == 7'h00)      rd = {17'd0, m_err[m_sel], 5'd0, 3'(m_sel)};
      else if (adr == 7'h20) rd = 32'(m_sel);
      else if (grp >= 0)     rd = 32'(m_ptr[m_sel][grp]);
    end
    for (int c = 0; c < NCHAN; c++)
      upd[c] = gu || (we && adr == 7'h00 && dat[0] && (dat[16] || c == m_sel));
    if (we && adr == 7'h00 && dat[31]) m_err[m_sel] = '0;
    for (int c = 0; c < NCHAN; c++) begin
      if (upd[c]) begin
        for (int s = 0; s < NS; s++) m_active[c][s] = m_shadow[c][s];
        for (int g = 0; g < NG; g++) begin
          if (m_ptr[c][g] != 0) m_err[c][g] = 1'b1;
          m_ptr[c][g] = 0;
        end
      end
    end
    if (we && grp >= 0) begin
      m_shadow[m_sel][first_slot(grp) + m_ptr[m_sel][grp]] = dat[17:0];
      m_ptr[m_sel][grp] = (m_ptr[m_sel][grp] + 1) % depth[grp];
    end
    if (we && adr == 7'h20 && int'(dat[2:0]) < NCHAN) m_sel = int'(dat[2:0]);
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [17:0] coeff_at(input int c, input int s);
    return coeff_o[(c*NS + s)*CBITS +: CBITS];
  endfunction

  task automatic chk_coeff(input string nm);
    int bc = -1, bs = -1;
    checks++;
    for (int c = 0; c < NCHAN; c++)
      for (int s = 0; s < NS; s++)
        if (bc < 0 && coeff_at(c, s) !== m_active[c][s]) begin
          bc = c;
          bs = s;
        end
    if (bc >= 0) begin
      errors++;
      $display("FAIL %s coeff ch%0d slot%0d: got %h expected %h", nm, bc, bs,
               coeff_at(bc, bs), m_active[bc][bs]);
    end
  endtask

  // One WISHBONE transfer, checked against the model.
  task automatic xfer(input bit we, input logic [6:0] adr, input logic [31:0] dat, input bit gu,
                      input string nm, output logic [31:0] rd, output logic [NCHAN-1:0] upd);
    logic [31:0]      exp_rd;
    logic [NCHAN-1:0] exp_upd;
    int n;
    model_step(we, adr, dat, gu, exp_rd, exp_upd);
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat = dat; gupd = gu;
    @(posedge clk); #1;
    gupd = 1'b0;
    n = 1;
    while (!wb_ack_o && n < 4) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " ack latency"}, 32'(n), 32'd1);
    rd  = wb_dat_o;
    upd = update_o;
    if (!we) chk({nm, " rdata"}, wb_dat_o, exp_rd);
    chk({nm, " update"}, 32'(update_o), 32'(exp_upd));
    @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
    chk({nm, " ack single"}, 32'(wb_ack_o), 32'd0);
    chk({nm, " update one-shot"}, 32'(update_o), 32'd0);
    chk_coeff(nm);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; gupd = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    rst_ni = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit          we;
    logic [6:0]  adr;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  vec_t             tbl [19];
  logic [31:0]      rd;
  logic [NCHAN-1:0] upd;
  logic             a0, a1, a2;

  initial begin
    tbl[0]  = '{1'b1, 7'h20, 32'h0000_0001, 32'h0};
    tbl[1]  = '{1'b0, 7'h20, 32'h0,         32'h1};
    tbl[2]  = '{1'b1, 7'h08, 32'h0001_1111, 32'h0};
    tbl[3]  = '{1'b0, 7'h08, 32'h0,         32'h1};
    tbl[4]  = '{1'b1, 7'h08, 32'h0002_2222, 32'h0};
    tbl[5]  = '{1'b1, 7'h08, 32'h0003_3333, 32'h0};
    tbl[6]  = '{1'b1, 7'h08, 32'h0000_4444, 32'h0};
    tbl[7]  = '{1'b0, 7'h08, 32'h0,         32'h0};
    tbl[8]  = '{1'b0, 7'h24, 32'h0,         32'h0};
    tbl[9]  = '{1'b1, 7'h40, 32'hFFFF_FFFF, 32'h0};
    tbl[10] = '{1'b0, 7'h40, 32'h0,         32'h0};
    tbl[11] = '{1'b1, 7'h14, 32'h0000_0005, 32'h0};
    tbl[12] = '{1'b0, 7'h14, 32'h0,         32'h1};
    tbl[13] = '{1'b1, 7'h00, 32'h0000_0001, 32'h0};
    tbl[14] = '{1'b0, 7'h00, 32'h0,         32'h0000_1001};
    tbl[15] = '{1'b0, 7'h14, 32'h0,         32'h0};
    tbl[16] = '{1'b1, 7'h00, 32'h8000_0000, 32'h0};
    tbl[17] = '{1'b0, 7'h00, 32'h0,         32'h0000_0001};
    tbl[18] = '{1'b0, 7'h0C, 32'h0,         32'h0};

    model_reset();
    do_reset();

    // Reset state
    chk("reset ack", 32'(wb_ack_o), 32'd0);
    chk("reset rdata", wb_dat_o, 32'd0);
    chk("reset update", 32'(update_o), 32'd0);
    chk_coeff("reset");

    // Table-driven register map walk
    for (int i = 0; i < 19; i++) begin
      xfer(tbl[i].we, tbl[i].adr, tbl[i].dat, 1'b0, $sformatf("tbl%0d", i), rd, upd);
      if (!tbl[i].we) chk($sformatf("tbl%0d const", i), rd, tbl[i].exp);
    end
    chk("tbl C slot8", 32'(coeff_at(1, 8)), 32'h11111);
    chk("tbl C slot11", 32'(coeff_at(1, 11)), 32'h04444);

    // Full zero-FIR load then commit on channel 0
    do_reset();
    for (int i = 0; i < 8; i++)
      xfer(1'b1, 7'h04, (i % 2 == 0) ? 32'h3FDAF : 32'h0375A, 1'b0, "zfir wr", rd, upd);
    xfer(1'b1, 7'h00, 32'h1, 1'b0, "zfir commit", rd, upd);
    chk("zfir pulse", 32'(upd), 32'h1);
    chk("zfir slot0", 32'(coeff_at(0, 0)), 32'h3FDAF);
    chk("zfir slot7", 32'(coeff_at(0, 7)), 32'h0375A);
    xfer(1'b0, 7'h00, 32'h0, 1'b0, "zfir ctrl rd", rd, upd);
    chk("zfir err", rd, 32'h0);

    // Partial F chain load
    xfer(1'b1, 7'h10, 32'h2205, 1'b0, "fch wr0", rd, upd);
    xfer(1'b1, 7'h10, 32'h0251, 1'b0, "fch wr1", rd, upd);
    xfer(1'b1, 7'h00, 32'h1, 1'b0, "fch commit", rd, upd);
    xfer(1'b0, 7'h00, 32'h0, 1'b0, "fch ctrl rd", rd, upd);
    chk("fch err bit11", rd, 32'h0000_0800);
    chk("fch slot16", 32'(coeff_at(0, 16)), 32'h2205);
    chk("fch slot17", 32'(coeff_at(0, 17)), 32'h0251);

    // Global update coinciding with an all-channel control commit
    xfer(1'b1, 7'h20, 32'h1, 1'b0, "gx sel", rd, upd);
    xfer(1'b1, 7'h1C, 32'h277, 1'b0, "gx wr", rd, upd);
    xfer(1'b1, 7'h00, 32'h10001, 1'b1, "gx commit", rd, upd);
    chk("gx pulse both", 32'(upd), 32'h3);
    chk("gx slot24", 32'(coeff_at(1, 24)), 32'h277);

    // Pointer wrap on a depth-8 group
    for (int i = 0; i < 9; i++)
      xfer(1'b1, 7'h04, 32'h100 + 32'(i), 1'b0, "wrap wr", rd, upd);
    xfer(1'b0, 7'h04, 32'h0, 1'b0, "wrap ptr", rd, upd);
    chk("wrap ptr const", rd, 32'h1);
    xfer(1'b1, 7'h00, 32'h1, 1'b0, "wrap commit", rd, upd);
    chk("wrap slot0", 32'(coeff_at(1, 0)), 32'h108);
    chk("wrap slot1", 32'(coeff_at(1, 1)), 32'h101);

    // Out-of-range channel select is ignored
    xfer(1'b1, 7'h20, 32'h7, 1'b0, "sel7 wr", rd, upd);
    xfer(1'b0, 7'h20, 32'h0, 1'b0, "sel7 rd", rd, upd);
    chk("sel7 kept", rd, 32'h1);

    // Held strobe: acks must alternate, never back-to-back
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 7'h20;
    @(posedge clk); #1; a0 = wb_ack_o;
    @(posedge clk); #1; a1 = wb_ack_o;
    @(posedge clk); #1; a2 = wb_ack_o;
    @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;
    chk("held ack0", 32'(a0), 32'd1);
    chk("held ack1", 32'(a1), 32'd0);
    chk("held ack2", 32'(a2), 32'd1);

    // Randomised traffic against the model
    for (int it = 0; it < 300; it++) begin
      int op;
      logic [31:0] d;
      logic [6:0]  a;
      op = $urandom_range(0, 9);
      d  = $urandom;
      if (op <= 4) begin
        a = 7'(4 + 4*$urandom_range(0, 6));
        xfer(1'b1, a, d, 1'b0, "rnd grp", rd, upd);
      end else if (op == 5) begin
        xfer(1'b1, 7'h20, d, 1'b0, "rnd sel", rd, upd);
      end else if (op == 6) begin
        a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'(4*$urandom_range(0, 8));
        xfer(1'b0, a, 32'h0, 1'b0, "rnd rd", rd, upd);
      end else if (op == 7) begin
        d = {d[31], 14'd0, d[16], 15'd0, d[0]};
        xfer(1'b1, 7'h00, d, 1'($urandom_range(0, 1)), "rnd ctrl", rd, upd);
      end else if (op == 8) begin
        xfer(1'b0, 7'(4*$urandom_range(0, 8)), 32'h0, 1'($urandom_range(0, 1)), "rnd rdgu", rd, upd);
      end else begin
        xfer(1'b0, 7'h00, 32'h0, 1'b0, "rnd ctrlrd", rd, upd);
      end
    end

    // Reset arriving during an active cycle
    for (int i = 0; i < 8; i++) xfer(1'b1, 7'h04, 32'h3A5A5, 1'b0, "pre rst wr", rd, upd);
    xfer(1'b1, 7'h00, 32'h10001, 1'b0, "pre rst commit", rd, upd);
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 7'h04; wb_dat = 32'h12345;
    rst_ni = 1'b0;
    @(posedge clk); #1;
    chk("midrst ack", 32'(wb_ack_o), 32'd0);
    chk("midrst update", 32'(update_o), 32'd0);
    chk("midrst rdata", wb_dat_o, 32'd0);
    chk("midrst coeff zero", 32'(|coeff_o), 32'd0);
    @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    rst_ni = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk("midrst no late ack", 32'(wb_ack_o), 32'd0);
    xfer(1'b1, 7'h04, 32'h12345, 1'b0, "retry wr", rd, upd);
    xfer(1'b0, 7'h04, 32'h0, 1'b0, "retry ptr", rd, upd);
    chk("retry ptr const", rd, 32'h1);
    xfer(1'b1, 7'h00, 32'h1, 1'b0, "retry commit", rd, upd);
    chk("retry slot0", 32'(coeff_at(0, 0)), 32'h12345);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
